// File: rtl/sipo_fifo_param.sv
// sipo_fifo_param: serial-in/parallel-out converter feeding a show-ahead word FIFO.
// Serial bits are taken on valid_i && ready_o and assembled into a WORD_WIDTH word,
// which is written into a DEPTH_FIFO-entry FIFO and presented on data_o/valid_o/ready_i.
// Optional macro SIPO_PARITY_EN adds an even-parity bit after each word; a word
// with a parity mismatch is dropped and parity_err_o pulses for one cycle.
module sipo_fifo_param #(
  parameter int WORD_WIDTH = 8,
  parameter int DEPTH_FIFO = 16,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [WORD_WIDTH-1:0]         data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(DEPTH_FIFO):0]   count_o,
  output logic                          parity_err_o
);

  localparam int AW = $clog2(DEPTH_FIFO);
  localparam int CW = AW + 1;
  localparam int BW = (WORD_WIDTH > 2) ? $clog2(WORD_WIDTH) : 1;

`ifdef SIPO_PARITY_EN
  typedef enum logic [3:0] {
    S_NO_DATA       = 4'b0001,
    S_FETCHING_DATA = 4'b0010,
    S_WRITE_FIFO    = 4'b0100,
    S_PARITY        = 4'b1000
  } state_t;
`else
  typedef enum logic [2:0] {
    S_NO_DATA       = 3'b001,
    S_FETCHING_DATA = 3'b010,
    S_WRITE_FIFO    = 3'b100
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [WORD_WIDTH-1:0] sh_q, sh_d;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [WORD_WIDTH-1:0] last_q;
  logic [WORD_WIDTH-1:0] mem [DEPTH_FIFO];
  logic                  accept, push, pop;
`ifdef SIPO_PARITY_EN
  logic                  perr_q, perr_d;
`endif

  // Serial side stalls during the write cycle and whenever the FIFO is full,
  // so a completed word always finds a free slot.
  assign ready_o = !rst_i && !flush_i && (state_q != S_WRITE_FIFO) &&
                   (count_q != CW'(DEPTH_FIFO));
  assign accept  = valid_i && ready_o;
  assign valid_o = (count_q != '0);
  assign pop     = valid_o && ready_i;
  assign count_o = count_q;
  assign data_o  = valid_o ? mem[rd_ptr_q] : last_q;
`ifdef SIPO_PARITY_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

  // Next-state, bit counter and shift register update.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    push    = 1'b0;
`ifdef SIPO_PARITY_EN
    perr_d  = 1'b0;
`endif
    case (state_q)
      S_NO_DATA, S_FETCHING_DATA: begin
        if (accept) begin
          sh_d = MSB_FIRST ? {sh_q[WORD_WIDTH-2:0], data_i}
                           : {data_i, sh_q[WORD_WIDTH-1:1]};
          if (bcnt_q == BW'(WORD_WIDTH - 1)) begin
            bcnt_d = '0;
`ifdef SIPO_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_WRITE_FIFO;
`endif
          end else begin
            bcnt_d  = bcnt_q + 1'b1;
            state_d = S_FETCHING_DATA;
          end
        end
      end
`ifdef SIPO_PARITY_EN
      S_PARITY: begin
        if (accept) begin
          if (^sh_q ^ data_i) begin
            perr_d  = 1'b1;
            state_d = S_NO_DATA;
          end else begin
            state_d = S_WRITE_FIFO;
          end
        end
      end
`endif
      S_WRITE_FIFO: begin
        push    = 1'b1;
        state_d = S_NO_DATA;
      end
      default: state_d = S_NO_DATA;
    endcase
  end

  // Control state: FSM, pointers, occupancy; flush clears everything but memory.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_NO_DATA;
      bcnt_q   <= '0;
      sh_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef SIPO_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else if (flush_i) begin
      state_q  <= S_NO_DATA;
      bcnt_q   <= '0;
      sh_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef SIPO_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
`ifdef SIPO_PARITY_EN
      perr_q  <= perr_d;
`endif
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Remember the last presented word so data_o holds steady once the FIFO drains.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        last_q <= '0;
    else if (valid_o) last_q <= mem[rd_ptr_q];
  end

  // Word storage; stale entries are harmless because pointers gate every read.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= sh_q;
  end

endmodule

// File: tb/tb_sipo_fifo_param.sv
// Directed bench for sipo_fifo_param: two instances (LSB-first and MSB-first,
// depth 4) share the same stimulus; outputs are sampled on the falling edge.
module tb_sipo_fifo_param;

  logic clk = 1'b0;
  logic rst, flush, din, vin, rdy_in;
  logic rdy1, rdy2, val1, val2, pe1, pe2;
  logic [7:0] d1, d2;
  logic [2:0] c1, c2;
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  sipo_fifo_param #(.WORD_WIDTH(8), .DEPTH_FIFO(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(din), .valid_i(vin),
    .ready_o(rdy1), .data_o(d1), .valid_o(val1), .ready_i(rdy_in),
    .count_o(c1), .parity_err_o(pe1));

  sipo_fifo_param #(.WORD_WIDTH(8), .DEPTH_FIFO(4), .MSB_FIRST(1'b1)) u_msb (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(din), .valid_i(vin),
    .ready_o(rdy2), .data_o(d2), .valid_o(val2), .ready_i(rdy_in),
    .count_o(c2), .parity_err_o(pe2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one bit at a falling edge and return at the falling edge after acceptance.
  task automatic send_bit(input logic b);
    int n;
    n = 0;
    din = b;
    vin = 1'b1;
    #1;
    while (!rdy1 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    vin = 1'b0;
  endtask

  // Bit i of w is sent i-th, so the LSB-first instance reassembles w.
  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
`ifdef SIPO_PARITY_EN
    send_bit(^w);
`endif
  endtask

  task automatic pop_one;
    rdy_in = 1'b1;
    @(negedge clk);
    rdy_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; din = 1'b0; vin = 1'b0; rdy_in = 1'b0;
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_ready", rdy1, 1'b0);
    chk("rst_valid", val1, 1'b0);
    chk("rst_count", c1, 3'd0);
    chk("rst_data", d1, 8'h00);
    chk("rst_perr", pe1, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", rdy1, 1'b1);
    @(negedge clk);

    // Single word A5, latency check
    send_word(8'hA5);
    chk("lat_valid_early", val1, 1'b0);
    @(negedge clk);
    chk("lat_valid", val1, 1'b1);
    chk("a5_lsb", d1, 8'hA5);
    chk("a5_msb", d2, 8'hA5);
    chk("a5_count", c1, 3'd1);
    pop_one();
    chk("pop_count", c1, 3'd0);
    chk("pop_valid", val1, 1'b0);
    chk("hold_data", d1, 8'hA5);

    // Bit order: stream 1,0,0,0,0,0,0,0
    send_word(8'h01);
    @(negedge clk);
    chk("order_lsb", d1, 8'h01);
    chk("order_msb", d2, 8'h80);
    pop_one();

    // Fill to full with sink stalled
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    send_word(8'h44);
    @(negedge clk);
    chk("full_count", c1, 3'd4);
    chk("full_ready", rdy1, 1'b0);
    din = 1'b1; vin = 1'b1;
    repeat (2) @(negedge clk);
    chk("stall_count", c1, 3'd4);
    chk("stall_ready", rdy1, 1'b0);
    vin = 1'b0;
    chk("head_11", d1, 8'h11);
    pop_one();
    #1;
    chk("after_pop_count", c1, 3'd3);
    chk("after_pop_ready", rdy1, 1'b1);
    send_word(8'h55);
    @(negedge clk);
    chk("refull_count", c1, 3'd4);
    chk("rd_22", d1, 8'h22); pop_one();
    chk("rd_33", d1, 8'h33); pop_one();
    chk("rd_44", d1, 8'h44); pop_one();
    chk("rd_55", d1, 8'h55); pop_one();
    chk("drain_count", c1, 3'd0);

    // Simultaneous push and pop at count 2
    send_word(8'h66);
    send_word(8'h77);
    @(negedge clk);
    chk("pp_pre_count", c1, 3'd2);
    send_word(8'h88);
    pop_one();
    chk("pp_count", c1, 3'd2);
    chk("pp_head", d1, 8'h77);
    pop_one();
    chk("pp_tail", d1, 8'h88);
    pop_one();
    chk("pp_drain", c1, 3'd0);

    // Flush mid-word with three words stored
    send_word(8'h01);
    send_word(8'h02);
    send_word(8'h03);
    @(negedge clk);
    chk("fl_pre_count", c1, 3'd3);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    flush = 1'b1; din = 1'b1; vin = 1'b1; rdy_in = 1'b1;
    #1;
    chk("fl_ready", rdy1, 1'b0);
    @(negedge clk);
    flush = 1'b0; vin = 1'b0; rdy_in = 1'b0;
    chk("fl_count", c1, 3'd0);
    chk("fl_valid", val1, 1'b0);
    send_word(8'h3C);
    @(negedge clk);
    chk("fl_new_word", d1, 8'h3C);
    chk("fl_new_count", c1, 3'd1);
    pop_one();

`ifdef SIPO_PARITY_EN
    // Parity: 07 has odd weight, so parity bit 1 matches and 0 mismatches
    for (int i = 0; i < 8; i++) send_bit(i < 3);
    send_bit(1'b1);
    @(negedge clk);
    chk("par_ok_count", c1, 3'd1);
    chk("par_ok_data", d1, 8'h07);
    for (int i = 0; i < 8; i++) send_bit(i < 3);
    send_bit(1'b0);
    chk("par_err_pulse", pe1, 1'b1);
    chk("par_err_count", c1, 3'd1);
    @(negedge clk);
    chk("par_err_clear", pe1, 1'b0);
    chk("par_err_count2", c1, 3'd1);
    pop_one();
`else
    chk("perr_tied_lsb", pe1, 1'b0);
    chk("perr_tied_msb", pe2, 1'b0);
`endif

    // Reset mid-word: no spurious word afterwards
    send_word(8'h99);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst = 1'b1;
    #1;
    chk("rst2_ready", rdy1, 1'b0);
    chk("rst2_count", c1, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst2_valid", val1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
